cartridge_bus_master: RTL and testbench

Initiator for the GBC cartridge bus: converts single-beat read/write requests from the memory-map/CPU side into timed cartridge bus cycles on a 16-bit address, a tri-state 8-bit data bus and active-low RE/WE strobes. It is the counterpart of the cartridge responder models and connects directly to them in simulation and to the cartridge pins on hardware. Setup, strobe and hold durations are parameterised so the same block serves both BRAM-backed sims and real cartridges.

---
 rtl/cartridge_bus_master.sv | 127 ++++++++++++
 tb/tb_cartridge_bus_master.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/cartridge_bus_master.sv
// Cartridge bus initiator: turns single-beat read/write requests into timed
// SETUP/STROBE/HOLD cycles on the cartridge address, data and strobe pins.
module cartridge_bus_master #(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic        I_CLK,
  input  logic        I_RESET,
  input  logic        I_REQ,
  input  logic        I_REQ_WE,
  input  logic [15:0] I_REQ_ADDR,
  input  logic [7:0]  I_REQ_WDATA,
  output logic        O_REQ_READY,
  output logic [7:0]  O_RDATA,
  output logic        O_DONE,
  output logic        O_BUSY,
  output logic [15:0] O_CARTRIDGE_ADDR,
  inout  wire  [7:0]  IO_CARTRIDGE_DATA,
  output logic        O_CARTRIDGE_WE_L,
  output logic        O_CARTRIDGE_RE_L
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;
  logic [7:0]  rdata_q;
  logic        re_l_q, we_l_q, oe_q, done_q;
  logic        accept, cnt_zero, we_nx;

  assign accept   = I_REQ && (state_q == IDLE);
  assign cnt_zero = (cnt_q == 4'd0);
  assign we_nx    = accept ? I_REQ_WE : we_q;

  // State register
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (accept)   state_d = SETUP;
      SETUP:  if (cnt_zero) state_d = STROBE;
      STROBE: if (cnt_zero) state_d = HOLD;
      HOLD:   if (cnt_zero) state_d = IDLE;
      default:              state_d = IDLE;
    endcase
  end

  // Combinational handshake outputs
  always_comb begin
    O_REQ_READY = (state_q == IDLE);
    O_BUSY      = (state_q != IDLE);
  end

  // Shared down-counter, reloaded on every state change
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      cnt_q <= 4'd0;
    end else if (state_d != state_q) begin
      case (state_d)
        SETUP:   cnt_q <= SETUP_LD;
        STROBE:  cnt_q <= STROBE_LD;
        HOLD:    cnt_q <= HOLD_LD;
        default: cnt_q <= 4'd0;
      endcase
    end else if (!cnt_zero) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  // Request latches; sampled only at accept so busy-time changes are ignored
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      we_q    <= 1'b0;
      addr_q  <= 16'h0000;
      wdata_q <= 8'h00;
    end else if (accept) begin
      we_q    <= I_REQ_WE;
      addr_q  <= I_REQ_ADDR;
      wdata_q <= I_REQ_WDATA;
    end
  end

  // Pin controls come from flops decoded off the next state, so they are
  // glitch-free and drop back asynchronously on reset.
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      re_l_q <= 1'b1;
      we_l_q <= 1'b1;
      oe_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      re_l_q <= !((state_d == STROBE) && !we_nx);
      we_l_q <= !((state_d == STROBE) &&  we_nx);
      oe_q   <= (state_d != IDLE) && we_nx;
      done_q <= (state_q == HOLD) && cnt_zero;
    end
  end

  // Read data captured on the edge leaving STROBE
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET)
      rdata_q <= 8'h00;
    else if ((state_q == STROBE) && cnt_zero && !we_q)
      rdata_q <= IO_CARTRIDGE_DATA;
  end

  assign O_RDATA           = rdata_q;
  assign O_DONE            = done_q;
  assign O_CARTRIDGE_ADDR  = addr_q;
  assign O_CARTRIDGE_RE_L  = re_l_q;
  assign O_CARTRIDGE_WE_L  = we_l_q;
  assign IO_CARTRIDGE_DATA = oe_q ? wdata_q : 8'hzz;

endmodule

// File: tb/tb_cartridge_bus_master.sv
// Directed bench for cartridge_bus_master: a memory responder on the bus,
// a read-data scoreboard, and a second instance with stretched timing.
module tb_cartridge_bus_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0, req_we = 1'b0;
  logic [15:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        ready, done, busy, we_l, re_l;
  logic [7:0]  rdata;
  logic [15:0] addr;
  wire  [7:0]  bus;

  logic        req2 = 1'b0;
  logic        ready2, done2, busy2, we2_l, re2_l;
  logic [7:0]  rdata2;
  logic [15:0] addr2;
  wire  [7:0]  bus2;

  always #5 clk = ~clk;

  cartridge_bus_master u_dut (
    .I_CLK(clk), .I_RESET(rst), .I_REQ(req), .I_REQ_WE(req_we),
    .I_REQ_ADDR(req_addr), .I_REQ_WDATA(req_wdata), .O_REQ_READY(ready),
    .O_RDATA(rdata), .O_DONE(done), .O_BUSY(busy), .O_CARTRIDGE_ADDR(addr),
    .IO_CARTRIDGE_DATA(bus), .O_CARTRIDGE_WE_L(we_l), .O_CARTRIDGE_RE_L(re_l));

  cartridge_bus_master #(.SETUP_CYCLES(2), .STROBE_CYCLES(4), .HOLD_CYCLES(1)) u_dut2 (
    .I_CLK(clk), .I_RESET(rst), .I_REQ(req2), .I_REQ_WE(1'b0),
    .I_REQ_ADDR(16'h0042), .I_REQ_WDATA(8'h00), .O_REQ_READY(ready2),
    .O_RDATA(rdata2), .O_DONE(done2), .O_BUSY(busy2), .O_CARTRIDGE_ADDR(addr2),
    .IO_CARTRIDGE_DATA(bus2), .O_CARTRIDGE_WE_L(we2_l), .O_CARTRIDGE_RE_L(re2_l));

  // Responder models: drive only while RE_L is low, capture writes during WE_L
  logic [7:0] mem [0:65535];
  assign bus  = !re_l  ? mem[addr] : 8'hzz;
  assign bus2 = !re2_l ? 8'h5A     : 8'hzz;
  always @(posedge clk) if (!we_l) mem[addr] <= bus;

  int checks = 0, failures = 0;
  int cyc = 0, done_cnt = 0, re_cyc = 0, we_cyc = 0, drv_cyc = 0, re2_cyc = 0;
  logic [7:0] sb[$];
  logic [7:0] exp_rd = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Per-cycle monitor sampled 1 time unit after each rising edge
  always @(posedge clk) begin
    cyc++;
    #1;
    if (!re_l)  re_cyc++;
    if (!we_l)  we_cyc++;
    if (!re2_l) re2_cyc++;
    if (re_l && bus !== 8'hzz) drv_cyc++;
    if (!re_l && !we_l) chk("strobe_overlap", 1, 0);
    if (done) begin
      done_cnt++;
      if (sb.size() == 0) chk("sb_unexpected_done", 1, 0);
      else chk("sb_rdata", rdata, sb.pop_front());
    end
  end

  task automatic do_req(input logic we, input logic [15:0] a, input logic [7:0] d,
                        output int lat);
    int guard = 0;
    while (!ready && guard < 50) begin @(negedge clk); guard++; end
    @(negedge clk);
    req = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    if (!we) exp_rd = mem[a];
    sb.push_back(exp_rd);
    @(posedge clk);
    #1 req = 1'b0;
    lat = 0;
    while (lat < 50) begin
      @(posedge clk); lat++; #1;
      if (done) break;
    end
  endtask

  task automatic clr_mon();
    re_cyc = 0; we_cyc = 0; drv_cyc = 0; re2_cyc = 0;
  endtask

  initial begin
    int lat, d0, t0, t1, t2, tguard;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0150] = 8'hCE;
    mem[16'h0100] = 8'h11; mem[16'h0101] = 8'h22; mem[16'h0102] = 8'h33;

    // Reset with bus idle
    repeat (2) @(posedge clk);
    #2;
    chk("rst_ready", ready, 1); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    chk("rst_rdata", rdata, 8'h00); chk("rst_addr", addr, 16'h0000);
    chk("rst_we_l", we_l, 1); chk("rst_re_l", re_l, 1); chk("rst_bus_z", bus === 8'hzz, 1);
    @(negedge clk) rst = 1'b0;

    // Read 0x0150 with default timing
    clr_mon();
    do_req(1'b0, 16'h0150, 8'h00, lat);
    chk("rd_latency", lat, 4); chk("rd_re_width", re_cyc, 2);
    chk("rd_no_drive", drv_cyc, 0); chk("rd_rdata", rdata, 8'hCE);

    // Write 0xA5 to 0x2000, then read it back
    clr_mon();
    do_req(1'b1, 16'h2000, 8'hA5, lat);
    chk("wr_latency", lat, 4); chk("wr_we_width", we_cyc, 2); chk("wr_re_width", re_cyc, 0);
    chk("wr_drive_cycles", drv_cyc, 4); chk("wr_bus_released", bus === 8'hzz, 1);
    chk("wr_rdata_kept", rdata, 8'hCE); chk("wr_mem", mem[16'h2000], 8'hA5);
    do_req(1'b0, 16'h2000, 8'h00, lat);
    chk("rdback_rdata", rdata, 8'hA5);

    // Back-to-back reads with I_REQ held high
    @(negedge clk);
    req = 1'b1; req_we = 1'b0; req_addr = 16'h0100;
    d0 = done_cnt; t0 = 0; t1 = 0;
    for (int i = 0; i < 3; i++) begin
      tguard = 0;
      while (!ready && tguard < 20) begin @(negedge clk); tguard++; end
      exp_rd = mem[req_addr];
      sb.push_back(exp_rd);
      @(posedge clk);
      t1 = cyc;
      #1;
      if (i > 0) chk("b2b_period", t1 - t0, 5);
      chk("b2b_ready_low", ready, 0);
      chk("b2b_addr", addr, 16'h0100 + 16'(i));
      t0 = t1;
      if (i < 2) req_addr = 16'h0101 + 16'(i);
      else req = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk("b2b_addr_held", addr, 16'h0100 + 16'(i));
    end
    tguard = 0;
    while (!ready && tguard < 20) begin @(negedge clk); tguard++; end
    repeat (2) @(negedge clk);
    chk("b2b_done_pulses", done_cnt - d0, 3); chk("b2b_last_rdata", rdata, 8'h33);

    // Busy-ignore: change request inputs after accept
    clr_mon(); d0 = done_cnt;
    @(negedge clk);
    req = 1'b1; req_we = 1'b0; req_addr = 16'h0150;
    exp_rd = 8'hCE; sb.push_back(exp_rd);
    @(posedge clk);
    #1 req_addr = 16'h2000; req_we = 1'b1; req_wdata = 8'h77;
    @(posedge clk); #1 req = 1'b1;
    @(posedge clk); #1 chk("ign_addr", addr, 16'h0150);
    req = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    chk("ign_one_done", done_cnt - d0, 1); chk("ign_no_write", we_cyc, 0);
    chk("ign_rdata", rdata, 8'hCE); chk("ign_mem", mem[16'h2000], 8'hA5);

    // Reset during a write strobe: pins released at once, no completion
    d0 = done_cnt;
    @(negedge clk);
    req = 1'b1; req_we = 1'b1; req_addr = 16'h3000; req_wdata = 8'h3C;
    @(posedge clk); #1 req = 1'b0;
    @(posedge clk); #1 chk("mid_we_low", we_l, 0);
    #2 rst = 1'b1;
    #1;
    chk("mid_we_l_async", we_l, 1); chk("mid_re_l_async", re_l, 1);
    chk("mid_bus_z", bus === 8'hzz, 1); chk("mid_ready", ready, 1);
    chk("mid_rdata", rdata, 8'h00); chk("mid_addr", addr, 16'h0000);
    @(negedge clk) rst = 1'b0;
    repeat (6) @(posedge clk);
    #2 chk("mid_no_done", done_cnt - d0, 0);

    // Stretched timing instance: SETUP=2, STROBE=4, HOLD=1
    clr_mon();
    @(negedge clk) req2 = 1'b1;
    @(posedge clk); t1 = cyc;
    #1 req2 = 1'b0;
    lat = 0;
    while (lat < 50) begin
      @(posedge clk); lat++; #1;
      if (done2) break;
    end
    chk("p2_latency", lat, 7); chk("p2_re_width", re2_cyc, 4); chk("p2_rdata", rdata2, 8'h5A);
    @(negedge clk) req2 = 1'b1;
    @(posedge clk); t1 = cyc;
    #1;
    tguard = 0;
    while (!ready2 && tguard < 30) begin @(negedge clk); tguard++; end
    @(posedge clk); t2 = cyc;
    #1 req2 = 1'b0;
    chk("p2_period", t2 - t1, 8);
    repeat (10) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
